// File: rtl/sseg_pkg.sv
// Shared types, constants and the hex-to-segment encoder for the seven-segment scan driver.
package sseg_pkg;

   typedef logic [3:0] sseg_digit_t;
   typedef logic [6:0] sseg_pattern_t;

   localparam int unsigned   SSEG_NUM_DIGITS = 8;
   localparam sseg_pattern_t SSEG_BLANK      = 7'h7F;
   localparam logic [31:0]   SSEG_DEC_MAX    = 32'd99_999_999;

   // Active-low pattern, bit 6 = segment a ... bit 0 = segment g.
   function automatic sseg_pattern_t sseg_encode(input sseg_digit_t d);
      case (d)
         4'h0:    return 7'b0000001;
         4'h1:    return 7'b1001111;
         4'h2:    return 7'b0010010;
         4'h3:    return 7'b0000110;
         4'h4:    return 7'b1001100;
         4'h5:    return 7'b0100100;
         4'h6:    return 7'b0100000;
         4'h7:    return 7'b0001111;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0000100;
         4'hA:    return 7'b0001000;
         4'hB:    return 7'b1100000;
         4'hC:    return 7'b0110001;
         4'hD:    return 7'b1000010;
         4'hE:    return 7'b0110000;
         default: return 7'b0111000;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-iteration double-dabble converter; done marks the edge that finishes the last
// iteration, with bcd carrying that final result combinationally.
module bin2bcd_seq
   import sseg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] bin,
   output logic        busy,
   output logic        done,
   output logic [31:0] bcd
);

   typedef enum logic [0:0] {StIdle, StConvert} state_e;

   state_e      state_q;
   logic [31:0] shift_q;
   logic [31:0] acc_q;
   logic [4:0]  iter_q;
   logic [30:0] adj;

   // Top nibble only needs its low three bits: inputs are saturated below 10^8.
   always_comb begin
      adj = acc_q[30:0];
      for (int i = 0; i < SSEG_NUM_DIGITS - 1; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
      adj[30:28] = acc_q[30:28] + ((acc_q[31:28] >= 4'd5) ? 3'd3 : 3'd0);
   end

   assign bcd  = {adj, shift_q[31]};
   assign busy = (state_q == StConvert);
   assign done = busy && (iter_q == 5'd31);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         acc_q   <= '0;
         iter_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  shift_q <= bin;
                  acc_q   <= '0;
                  iter_q  <= '0;
                  state_q <= StConvert;
               end
            end
            StConvert: begin
               acc_q   <= bcd;
               shift_q <= {shift_q[30:0], 1'b0};
               iter_q  <= iter_q + 5'd1;
               if (iter_q == 5'd31) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: rtl/sseg_scan_driver.sv
// Captures a value as hex or decimal digits and scans them onto active-low segment/anode lines.
// Optional SSEG_BLANK_LEADING_ZEROS_EN blanks digits above the most significant non-zero one.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int unsigned C_REFRESH_DIV   = 16,
   parameter bit          C_SWAP_SEGMENTS = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] value,
   input  logic        dec,
   output logic        busy,
   output logic        ovf,
   output logic [6:0]  segments,
   output logic [7:0]  anodes
);

   localparam int unsigned     CntW   = (C_REFRESH_DIV > 1) ? $clog2(C_REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(C_REFRESH_DIV - 1);

   logic [CntW-1:0] refresh_q;
   logic [2:0]      index_q;
   logic [31:0]     digits_q, digits_d;
   logic            ovf_q;
   sseg_pattern_t   segments_q, segments_d;
   logic [7:0]      anodes_q, anodes_d;

   logic            conv_busy, conv_done;
   logic [31:0]     conv_bcd;
   logic            hex_load, dec_start;
   logic [31:0]     dec_value;

   assign hex_load  = load & ~dec & ~conv_busy;
   assign dec_start = load & dec & ~conv_busy;
   assign dec_value = (value > SSEG_DEC_MAX) ? SSEG_DEC_MAX : value;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (dec_start),
      .bin   (dec_value),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // hex_load and conv_done are exclusive: a hex load is only accepted while not converting.
   always_comb begin
      digits_d = digits_q;
      if (hex_load)       digits_d = value;
      else if (conv_done) digits_d = conv_bcd;
   end

`ifdef SSEG_BLANK_LEADING_ZEROS_EN
   logic [7:0] blank_q, blank_d;

   always_comb begin
      blank_d = 8'h00;
      for (int i = 1; i < SSEG_NUM_DIGITS; i++) begin
         blank_d[i] = ((digits_d >> (4 * i)) == 32'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blank_q <= 8'hFE;
      end else if (hex_load || conv_done) begin
         blank_q <= blank_d;
      end
   end
`endif

   always_comb begin
      sseg_pattern_t pat;
      pat        = sseg_encode(digits_q[4*index_q +: 4]);
      segments_d = pat;
      if (C_SWAP_SEGMENTS) begin
         for (int b = 0; b < 7; b++) segments_d[b] = pat[6-b];
      end
      anodes_d = ~(8'b1 << index_q);
`ifdef SSEG_BLANK_LEADING_ZEROS_EN
      if (blank_q[index_q]) begin
         anodes_d   = 8'hFF;
         segments_d = SSEG_BLANK;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_q  <= '0;
         index_q    <= '0;
         digits_q   <= '0;
         ovf_q      <= 1'b0;
         segments_q <= SSEG_BLANK;
         anodes_q   <= 8'hFF;
      end else begin
         digits_q   <= digits_d;
         segments_q <= segments_d;
         anodes_q   <= anodes_d;
         if (dec_start) ovf_q <= (value > SSEG_DEC_MAX);
         if (refresh_q == CntMax) begin
            refresh_q <= '0;
            index_q   <= index_q + 3'd1;
         end else begin
            refresh_q <= refresh_q + CntW'(1);
         end
      end
   end

   assign busy     = conv_busy;
   assign ovf      = ovf_q;
   assign segments = segments_q;
   assign anodes   = anodes_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench: two driver instances (divide-by-4 normal order, divide-by-1 swapped order)
// share stimulus; a monitor decodes each full scan and compares against a queued expectation.
module tb_sseg_scan_driver;

   typedef struct packed {
      logic [31:0] digits;
      logic        ovf;
   } exp_t;

   localparam logic [6:0] ENC_TAB [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000,
      7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010,
      7'b0110000, 7'b0111000};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [31:0] value = '0;
   logic        dec = 1'b0;
   logic        busy, ovf, busy2, ovf2;
   logic [6:0]  segments, segments2;
   logic [7:0]  anodes, anodes2;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   logic model_ovf = 1'b0;

   always #5 clk = ~clk;

   sseg_scan_driver #(.C_REFRESH_DIV(4), .C_SWAP_SEGMENTS(1'b0)) u_dut (
      .clk(clk), .rst(rst), .load(load), .value(value), .dec(dec),
      .busy(busy), .ovf(ovf), .segments(segments), .anodes(anodes));

   sseg_scan_driver #(.C_REFRESH_DIV(1), .C_SWAP_SEGMENTS(1'b1)) u_dut2 (
      .clk(clk), .rst(rst), .load(load), .value(value), .dec(dec),
      .busy(busy2), .ovf(ovf2), .segments(segments2), .anodes(anodes2));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int dec7(input logic [6:0] pat, input bit rev);
      logic [6:0] p;
      p = pat;
      if (rev) for (int b = 0; b < 7; b++) p[b] = pat[6-b];
      for (int k = 0; k < 16; k++) if (ENC_TAB[k] == p) return k;
      return -1;
   endfunction

   // Reference: hex = nibbles as-is; decimal = base-10 digits of the saturated value.
   function automatic logic [31:0] model_digits(input logic [31:0] v, input bit d);
      longint unsigned n;
      logic [31:0]     r;
      if (!d) return v;
      n = (v > 32'd99_999_999) ? 64'd99_999_999 : {32'd0, v};
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(n % 10);
         n = n / 10;
      end
      return r;
   endfunction

   task automatic do_load(input logic [31:0] v, input bit d, input bit push);
      exp_t e;
      @(negedge clk);
      load  = 1'b1;
      value = v;
      dec   = d;
      if (push) begin
         if (d) model_ovf = (v > 32'd99_999_999);
         e.digits = model_digits(v, d);
         e.ovf    = model_ovf;
         exp_q.push_back(e);
      end
      @(negedge clk);
      load  = 1'b0;
      value = $urandom;
      dec   = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_reset_vals();
      check("rst_anodes", anodes, 8'hFF);
      check("rst_segments", segments, 7'h7F);
      check("rst_busy", busy, 0);
      check("rst_ovf", ovf, 0);
      check("rst_anodes2", anodes2, 8'hFF);
      check("rst_ovf2", ovf2, 0);
   endtask

   // Monitor: once busy has been low for 3 samples, decode one full scan and compare.
   initial begin : monitor
      int          quiet;
      int          p;
      int          oh_err;
      int          blank_err;
      bit          bad;
      logic [31:0] d1, d2;
      exp_t        e;
      quiet = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0 || rst) begin
            quiet = 0;
            continue;
         end
         if (busy || busy2) quiet = 0;
         else quiet++;
         if (quiet >= 3) begin
            d1 = '0; d2 = '0; bad = 0; oh_err = 0; blank_err = 0;
            for (int c = 0; c < 32; c++) begin
               @(negedge clk);
               for (int k = 0; k < 8; k++) begin
                  if (!anodes[k]) begin
                     p = dec7(segments, 1'b0);
                     if (p < 0) bad = 1; else d1[4*k +: 4] = p[3:0];
                  end
                  if (!anodes2[k]) begin
                     p = dec7(segments2, 1'b1);
                     if (p < 0) bad = 1; else d2[4*k +: 4] = p[3:0];
                  end
               end
`ifdef SSEG_BLANK_LEADING_ZEROS_EN
               if ($countones(~anodes) > 1 || $countones(~anodes2) > 1) oh_err++;
               if (exp_q[0].digits == 32'hA0 && anodes[7:2] != 6'h3F) blank_err++;
`else
               if ($countones(~anodes) != 1 || $countones(~anodes2) != 1) oh_err++;
`endif
            end
            e = exp_q.pop_front();
            check("digits_div4", d1, e.digits);
            check("digits_swap", d2, e.digits);
            check("ovf", ovf, e.ovf);
            check("ovf2", ovf2, e.ovf);
            check("pattern_valid", bad, 0);
            check("anode_onehot", oh_err, 0);
            check("blank_lead", blank_err, 0);
            quiet = 0;
         end
      end
   end

   initial begin : stimulus
      int          cnt;
      logic [7:0]  ea1, ea2;
      logic [31:0] v;
      bit          d;

      repeat (3) @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      // Scan order and slot length from reset release; c = 0 is the first post-reset cycle.
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         ea1 = ~(8'b1 << ((c / 4) % 8));
         ea2 = ~(8'b1 << (c % 8));
`ifdef SSEG_BLANK_LEADING_ZEROS_EN
         if ((c / 4) % 8 != 0) ea1 = 8'hFF;
         if (c % 8 != 0) ea2 = 8'hFF;
`endif
         check("scan_an_div4", anodes, ea1);
         check("scan_an_div1", anodes2, ea2);
         if (c == 0) begin
            check("first_seg", segments, 7'b0000001);
            check("first_seg2", segments2, 7'b1000000);
         end
      end

      do_load(32'h1234ABCD, 1'b0, 1'b1);
      check("hex_busy", busy, 0);
      wait_drain();

      do_load(32'd12_345_678, 1'b1, 1'b1);
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("busy_len", cnt, 32);
      wait_drain();

      do_load(32'd100_000_000, 1'b1, 1'b1);
      wait_drain();
      do_load(32'd5, 1'b1, 1'b1);
      wait_drain();

      do_load(32'd42, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      do_load(32'hFFFF_FFFF, 1'b0, 1'b0);
      do_load(32'd200_000_000, 1'b1, 1'b0);
      check("busy_during_ignored", busy, 1);
      wait_drain();

      do_load(32'h0000_00A0, 1'b0, 1'b1);
      wait_drain();
      do_load(32'd99_999_999, 1'b1, 1'b1);
      wait_drain();
      do_load(32'd0, 1'b1, 1'b1);
      wait_drain();

      for (int i = 0; i < 12; i++) begin
         d = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 99_999_999);
            2:       v = $urandom_range(0, 999);
            default: v = 32'd99_999_999 + $urandom_range(0, 3);
         endcase
         do_load(v, d, 1'b1);
         wait_drain();
      end

      // Reset ten cycles into a saturating conversion: no commit and ovf cleared.
      do_load(32'd150_000_000, 1'b1, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      model_ovf = 1'b0;
      @(negedge clk);
      check("rel_anodes", anodes, 8'hFE);
      check("rel_segments", segments, 7'b0000001);
      check("rel_segments2", segments2, 7'b1000000);
      begin
         exp_t e;
         e.digits = '0;
         e.ovf    = 1'b0;
         exp_q.push_back(e);
      end
      wait_drain();
      check("post_rst_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
